// File: rtl/tdm_slot_sequencer_if.sv
// Control and select bundle between a slot sequencer and its host.
// The host drives the run controls and observes the select lines and strobes.
interface tdm_slot_sequencer_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [3:0]         chan_en;
    logic [DWELL_W-1:0] dwell;
    logic               s1;
    logic               s0;
    logic               slot_valid;
    logic               slot_first;
    logic               frame_sync;
    logic               frame_done;
    logic               busy;

    modport master (
        output start, stop, continuous, chan_en, dwell,
        input  s1, s0, slot_valid, slot_first, frame_sync, frame_done, busy
    );

    modport slave (
        input  start, stop, continuous, chan_en, dwell,
        output s1, s0, slot_valid, slot_first, frame_sync, frame_done, busy
    );
endinterface

// File: rtl/tdm_slot_sequencer.sv
// Steps the 4:1 MUX / 1:4 DEMUX select through the enabled channels, holding each for dwell+1 cycles.
// Outputs are registered; they describe the cycle that follows the edge that computed them.
module tdm_slot_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_slot_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SLOT} state_t;

    state_t             state, state_n;
    logic [1:0]         chan, chan_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [3:0]         mask_q, mask_n;
    logic               stop_q, stop_n;

    logic               s1_n, s0_n, valid_n, first_n, sync_n, done_n, busy_n;
    logic [2:0]         cur_next;
    logic [2:0]         new_next;

    function automatic logic [1:0] low_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    // {found, channel} of the next enabled channel above ch
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] ch);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (k > int'(ch) && m[k]) r = {1'b1, 2'(k)};
        end
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        chan_n   = chan;
        cnt_n    = cnt;
        mask_n   = mask_q;
        dwell_n  = dwell_q;
        stop_n   = stop_q;
        cur_next = next_above(mask_q, chan);

        unique case (state)
            IDLE: begin
                stop_n = 1'b0;
                if (bus.start && bus.chan_en != 4'b0000) begin
                    mask_n  = bus.chan_en;
                    dwell_n = bus.dwell;
                    chan_n  = low_ch(bus.chan_en);
                    cnt_n   = '0;
                    state_n = SLOT;
                end
            end
            SLOT: begin
                if (bus.stop) stop_n = 1'b1;
                if (cnt == dwell_q) begin
                    cnt_n = '0;
                    if (cur_next[2]) begin
                        chan_n = cur_next[1:0];
                    end else if (bus.continuous && !(stop_q || bus.stop)
                                 && bus.chan_en != 4'b0000) begin
                        mask_n  = bus.chan_en;
                        dwell_n = bus.dwell;
                        chan_n  = low_ch(bus.chan_en);
                    end else begin
                        state_n = IDLE;
                        stop_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs for the upcoming cycle, derived from the next-state registers
        new_next = next_above(mask_n, chan_n);
        s1_n     = 1'b0;
        s0_n     = 1'b0;
        valid_n  = 1'b0;
        first_n  = 1'b0;
        sync_n   = 1'b0;
        done_n   = 1'b0;
        busy_n   = 1'b0;
        if (state_n == SLOT) begin
            s1_n    = chan_n[1];
            s0_n    = chan_n[0];
            valid_n = 1'b1;
            busy_n  = 1'b1;
            first_n = (cnt_n == '0);
            sync_n  = (cnt_n == '0) && (chan_n == low_ch(mask_n));
            done_n  = (cnt_n == dwell_n) && !new_next[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            chan           <= 2'd0;
            cnt            <= '0;
            mask_q         <= 4'b0000;
            dwell_q        <= '0;
            stop_q         <= 1'b0;
            bus.s1         <= 1'b0;
            bus.s0         <= 1'b0;
            bus.slot_valid <= 1'b0;
            bus.slot_first <= 1'b0;
            bus.frame_sync <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_n;
            chan           <= chan_n;
            cnt            <= cnt_n;
            mask_q         <= mask_n;
            dwell_q        <= dwell_n;
            stop_q         <= stop_n;
            bus.s1         <= s1_n;
            bus.s0         <= s0_n;
            bus.slot_valid <= valid_n;
            bus.slot_first <= first_n;
            bus.frame_sync <= sync_n;
            bus.frame_done <= done_n;
            bus.busy       <= busy_n;
        end
    end
endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Randomized and directed bench; the reference model expands each frame into a queue of per-cycle outputs.
module tb_tdm_slot_sequencer;
    localparam int DWELL_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    tdm_slot_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    tdm_slot_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {busy, s1, s0, slot_valid, slot_first, frame_sync, frame_done}
    wire [6:0] got = {bus.busy, bus.s1, bus.s0, bus.slot_valid,
                      bus.slot_first, bus.frame_sync, bus.frame_done};

    logic [6:0] frame_q[$];
    logic       m_stop = 1'b0;

    function automatic logic [6:0] model_exp();
        return (frame_q.size() != 0) ? frame_q[0] : 7'b0;
    endfunction

    task automatic build_frame(input logic [3:0] m, input logic [DWELL_W-1:0] d);
        int n_en = 0;
        int seen = 0;
        for (int k = 0; k < 4; k++) if (m[k]) n_en++;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                seen++;
                for (int c = 0; c <= int'(d); c++) begin
                    logic [1:0] ch;
                    ch = 2'(k);
                    frame_q.push_back({1'b1, ch, 1'b1, c == 0,
                                       (c == 0) && (seen == 1),
                                       (seen == n_en) && (c == int'(d))});
                end
            end
        end
    endtask

    // One clock edge: the model consumes the inputs sampled at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            frame_q.delete();
            m_stop = 1'b0;
        end else if (frame_q.size() == 0) begin
            if (bus.start && bus.chan_en != 4'b0000) build_frame(bus.chan_en, bus.dwell);
        end else begin
            if (bus.stop) m_stop = 1'b1;
            void'(frame_q.pop_front());
            if (frame_q.size() == 0) begin
                if (bus.continuous && !m_stop && bus.chan_en != 4'b0000)
                    build_frame(bus.chan_en, bus.dwell);
                else
                    m_stop = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.continuous = 1'b0;
        bus.chan_en = 4'b0000;
        bus.dwell = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.start = 1'b1;
        bus.chan_en = 4'b1111;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [6:0] tbl[4];
        tbl = '{7'b1001110, 7'b1011100, 7'b1101100, 7'b1111101};
        idle_inputs();
        bus.chan_en = 4'b1111;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (got !== model_exp() || got !== ((i < 4) ? tbl[i] : 7'b0)) begin
                failures++;
                $display("FAIL single_frame cyc=%0d got=%b exp=%b", i + 1, got, model_exp());
            end
        end
    endtask

    task automatic test_skip_dwell();
        logic [1:0] sel[6];
        sel = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        idle_inputs();
        bus.chan_en = 4'b1010;
        bus.dwell = 4'd2;
        bus.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.start = 1'b0;
            if (i == 0) bus.dwell = 4'd0;
            checks++;
            if (got !== model_exp()) begin
                failures++;
                $display("FAIL skip_dwell cyc=%0d got=%b exp=%b", i + 1, got, model_exp());
            end
            if (i < 6) begin
                checks++;
                if ({bus.s1, bus.s0, bus.slot_first, bus.frame_done} !==
                    {sel[i], i == 0 || i == 3, i == 5}) begin
                    failures++;
                    $display("FAIL skip_dwell_tbl cyc=%0d got=%b%b%b%b", i + 1,
                             bus.s1, bus.s0, bus.slot_first, bus.frame_done);
                end
            end
        end
    endtask

    task automatic test_continuous_stop();
        idle_inputs();
        bus.chan_en = 4'b0101;
        bus.dwell = 4'd1;
        bus.continuous = 1'b1;
        bus.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            bus.start = 1'b0;
            bus.stop = (i == 6);
            checks++;
            if (got !== model_exp()) begin
                failures++;
                $display("FAIL cont_stop cyc=%0d got=%b exp=%b", i, got, model_exp());
            end
            checks++;
            if (i <= 8 && ({bus.s1, bus.s0, bus.busy} !== {((i - 1) % 4) >= 2, 1'b0, 1'b1})) begin
                failures++;
                $display("FAIL cont_stop_sel cyc=%0d got=%b%b%b", i, bus.s1, bus.s0, bus.busy);
            end else if (i > 8 && got !== 7'b0) begin
                failures++;
                $display("FAIL cont_stop_end cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
        bus.continuous = 1'b0;
    endtask

    task automatic test_ignored_start();
        idle_inputs();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL start_no_chan cyc=%0d got=%b exp=%b", i, got, 7'b0);
            end
        end
        bus.chan_en = 4'b1001;
        bus.dwell = 4'd1;
        for (int i = 1; i <= 5; i++) begin
            step();
            bus.start = (i == 2);
            if (i == 2) bus.chan_en = 4'b0110;
            checks++;
            if (got !== model_exp()) begin
                failures++;
                $display("FAIL start_mid_frame cyc=%0d got=%b exp=%b", i, got, model_exp());
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        idle_inputs();
        bus.chan_en = 4'b1111;
        bus.dwell = 4'd2;
        bus.start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            bus.start = 1'b0;
        end
        checks++;
        if ({bus.s1, bus.s0} !== 2'b10) begin
            failures++;
            $display("FAIL pre_reset_sel got=%b%b exp=10", bus.s1, bus.s0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (got !== 7'b0 || got !== model_exp()) begin
            failures++;
            $display("FAIL reset_mid_frame got=%b exp=%b", got, 7'b0);
        end
        step();
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got=%b exp=%b", got, 7'b0);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (got !== 7'b1001110 || got !== model_exp()) begin
            failures++;
            $display("FAIL restart got=%b exp=%b", got, 7'b1001110);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stop = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) bus.continuous = ~bus.continuous;
            bus.chan_en = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            bus.dwell = 4'($urandom_range(0, 3));
            step();
            checks++;
            if (got !== model_exp()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, got, model_exp());
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_frame();
        test_skip_dwell();
        test_continuous_stop();
        test_ignored_start();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_slot_sequencer.md
# tdm_slot_sequencer

Time-division slot sequencer that drives the select lines of the 4:1 channel multiplexer and the matching 1:4 demultiplexer. It steps through the enabled channels of a 4-bit channel mask and holds each slot for a programmable dwell, producing frame and slot strobes. It supports single-frame and continuous operation. It sits directly upstream of the MUX/DEMUX pair: its `s1`/`s0` connect straight to their select inputs.

## Interface
- `DWELL_W`, default 4: width of the dwell field; a slot lasts `dwell+1` cycles.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled; begins a frame when idle and `chan_en != 0`.
- `stop` in 1: single-cycle request; ends continuous operation at the next frame boundary.
- `continuous` in 1: sampled at each frame end; 1 = start the next frame back-to-back.
- `chan_en` in 4: channel enable mask; bit k enables channel k.
- `dwell` in DWELL_W: slot length minus one.
- `s1` out 1: select MSB (channel index bit 1).
- `s0` out 1: select LSB (channel index bit 0).
- `slot_valid` out 1: high in every cycle of an active slot.
- `slot_first` out 1: high in the first cycle of each slot.
- `frame_sync` out 1: high in the first cycle of the first slot of each frame.
- `frame_done` out 1: high in the last cycle of the last slot of each frame.
- `busy` out 1: high from the first slot cycle until the frame/run ends.

## Operation
- States: IDLE, SLOT.
- All outputs are registered. The reset value of every output is 0. Reset also clears the stop latch, the internal mask, the dwell copy and the dwell counter.
- **IDLE**
  - `s1`=`s0`=0, all strobes 0, `busy`=0.
  - `start`=1 with `chan_en!=0`: latch `chan_en` to mask_q and `dwell` to dwell_q, set channel = lowest set bit of mask_q, clear the counter, go to SLOT.
  - `start` with `chan_en==0` is ignored.
- **SLOT**
  - `{s1,s0}` = current channel and `slot_valid`=1. The counter counts 0..dwell_q.
  - `slot_first`=1 when the counter is 0.
  - `frame_sync`=1 when the counter is 0 and the channel is the lowest enabled bit.
  - At counter==dwell_q, the next channel is the next higher set bit of mask_q:
    - If it exists: switch to it and clear the counter.
    - If none exists, this is the frame end and `frame_done`=1 in that cycle. Then:
      - if `continuous`=1 and no stop is latched, relatch `chan_en`/`dwell` and restart at the lowest enabled channel with no gap cycle;
      - if the relatched `chan_en` is 0, go to IDLE instead;
      - otherwise go to IDLE.
- `stop` seen in SLOT sets a stop latch. The current frame always completes. The latch clears on entry to IDLE.
- `start` while in SLOT is ignored.
- `chan_en` and `dwell` changes mid-frame have no effect until the next frame latch.
- Disabled channels are skipped and never appear on `s1`/`s0`.

## Timing
- Latency: `start` sampled high at edge N gives, after edge N, `busy`=1, `slot_valid`=1, `slot_first`=1, `frame_sync`=1, and `{s1,s0}` = lowest enabled channel.
- Each slot holds `{s1,s0}` for exactly `dwell_q+1` cycles. A frame of m enabled channels lasts m·(dwell_q+1) cycles.
- `dwell`=0: every cycle is both `slot_first` and the slot's last cycle.
- Single enabled channel in continuous mode: `frame_sync`, `slot_first` and `frame_done` repeat every `dwell+1` cycles.
- Continuous mode: the cycle after `frame_done` carries `frame_sync` (no idle cycle). `busy` stays high across frames.
- Ending a run: the cycle after the final `frame_done`, all outputs are 0.
- `rst` mid-frame: the next cycle is IDLE with all outputs 0. No `frame_done` is issued for the aborted frame.
- `stop` and `frame_done` in the same cycle: that frame is the last one.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 → all outputs 0; release with `start`=0 → stays IDLE.
- Single frame, `chan_en`=1111, `dwell`=0, `continuous`=0, `start` pulse → `{s1,s0}` = 00,01,10,11 on 4 consecutive cycles; `frame_sync` on cycle 1, `frame_done` on cycle 4, `busy` 4 cycles, then all 0.
- Skip and dwell, `chan_en`=1010, `dwell`=2 → `{s1,s0}`=01 for 3 cycles then 11 for 3 cycles; `slot_first` on cycles 1 and 4; `frame_done` on cycle 6; changing `dwell` to 0 at cycle 2 has no effect.
- Continuous with stop, `chan_en`=0101, `dwell`=1, `continuous`=1; pulse `stop` on cycle 6 → frames repeat as 00,00,10,10 with no gap; the run ends after the frame containing cycle 6 (`frame_done` on cycle 8, IDLE on cycle 9).
- Ignored starts: `start` with `chan_en`=0000 → stays IDLE; `start` re-pulsed mid-frame → sequence unchanged.
- Reset mid-frame: assert `rst` during the channel-10 slot → next cycle all outputs 0, no `frame_done`; a new `start` then begins at the lowest enabled channel with `frame_sync`.
